// File: rtl/gate_bist_ctrl.sv
// -----------------------------------------------------------------------------
// gate_bist_ctrl
//   Built-in self-test sequencer for one 2-input library gate. On an accepted
//   start it drives the four {B,A} vectors 00,01,10,11, holds each one for
//   SETTLE_CYC cycles plus one sample cycle, compares the gate output with a
//   latched 4-bit expected truth table, and reports a per-vector fail mask, an
//   error count and a pass flag.
//
// Parameters
//   SETTLE_CYC  cycles each vector settles before it is sampled (1..15)
//   CNT_W       settle counter width, 2**CNT_W > SETTLE_CYC
//
// Ports
//   clk_i       in   1  clock, rising edge
//   rst_n_i     in   1  asynchronous active-low reset
//   start_i     in   1  start request, only looked at in IDLE
//   abort_i     in   1  synchronous abort, honoured outside IDLE
//   exp_tt_i    in   4  expected truth table, bit index = {B,A}; latched on start
//   F_i         in   1  output of the gate under test
//   A_o         out  1  gate input A (registered)
//   B_o         out  1  gate input B (registered)
//   busy_o      out  1  high in SETTLE, SAMPLE and DONE
//   done_o      out  1  one-cycle pulse in DONE
//   pass_o      out  1  all four vectors matched; valid with done_o
//   fail_vec_o  out  4  bit i set = vector i mismatched
//   err_cnt_o   out  3  number of set bits in fail_vec_o
// -----------------------------------------------------------------------------
module gate_bist_ctrl #(
   parameter int SETTLE_CYC = 2,
   parameter int CNT_W      = 4
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       start_i,
   input  logic       abort_i,
   input  logic [3:0] exp_tt_i,
   input  logic       F_i,
   output logic       A_o,
   output logic       B_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       pass_o,
   output logic [3:0] fail_vec_o,
   output logic [2:0] err_cnt_o
);

   if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_settle
      $error("gate_bist_ctrl: SETTLE_CYC must be in 1..15");
   end
   if ((2 ** CNT_W) <= SETTLE_CYC) begin : g_bad_cnt_w
      $error("gate_bist_ctrl: CNT_W too narrow for SETTLE_CYC");
   end

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_SAMPLE,
      ST_DONE
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [3:0]       r_tt,    w_tt_nxt;
   logic [1:0]       r_idx,   w_idx_nxt;
   logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
   logic [1:0]       r_ab,    w_ab_nxt;
   logic             r_busy,  w_busy_nxt;
   logic             r_done,  w_done_nxt;
   logic             r_pass,  w_pass_nxt;
   logic [3:0]       r_fail,  w_fail_nxt;
   logic [2:0]       r_err,   w_err_nxt;

   // Every output is a register loaded with the value for the state being
   // entered, so busy/done/pass and {B,A} line up with the state they describe.
   always_comb begin
      w_state_nxt = r_state;
      w_tt_nxt    = r_tt;
      w_idx_nxt   = r_idx;
      w_cnt_nxt   = r_cnt;
      w_ab_nxt    = r_ab;
      w_done_nxt  = 1'b0;
      w_pass_nxt  = r_pass;
      w_fail_nxt  = r_fail;
      w_err_nxt   = r_err;

      unique case (r_state)
         ST_IDLE: begin
            if (start_i) begin
               w_tt_nxt    = exp_tt_i;
               w_idx_nxt   = '0;
               w_ab_nxt    = '0;
               w_fail_nxt  = '0;
               w_err_nxt   = '0;
               w_pass_nxt  = 1'b0;
               w_cnt_nxt   = '0;
               w_state_nxt = ST_SETTLE;
            end
         end

         ST_SETTLE: begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (r_cnt == CNT_LAST) begin
               w_state_nxt = ST_SAMPLE;
            end
         end

         ST_SAMPLE: begin
            if (F_i != r_tt[r_idx]) begin
               w_fail_nxt[r_idx] = 1'b1;
               w_err_nxt         = r_err + 3'd1;
            end
            if (r_idx != 2'd3) begin
               w_idx_nxt   = r_idx + 2'd1;
               w_ab_nxt    = r_idx + 2'd1;
               w_cnt_nxt   = '0;
               w_state_nxt = ST_SETTLE;
            end else begin
               // Pass is resolved on entry to DONE (including vector 3's
               // result just computed) so it is valid together with done_o.
               w_ab_nxt    = '0;
               w_pass_nxt  = (w_fail_nxt == 4'd0);
               w_done_nxt  = 1'b1;
               w_state_nxt = ST_DONE;
            end
         end

         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      // Abort overrides everything above, including the SAMPLE update;
      // partial fail mask and error count are kept.
      if (abort_i && (r_state != ST_IDLE)) begin
         w_state_nxt = ST_IDLE;
         w_ab_nxt    = '0;
         w_done_nxt  = 1'b0;
         w_pass_nxt  = 1'b0;
         w_fail_nxt  = r_fail;
         w_err_nxt   = r_err;
      end

      w_busy_nxt = (w_state_nxt != ST_IDLE);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= ST_IDLE;
         r_tt    <= '0;
         r_idx   <= '0;
         r_cnt   <= '0;
         r_ab    <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_pass  <= 1'b0;
         r_fail  <= '0;
         r_err   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_tt    <= w_tt_nxt;
         r_idx   <= w_idx_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ab    <= w_ab_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_pass  <= w_pass_nxt;
         r_fail  <= w_fail_nxt;
         r_err   <= w_err_nxt;
      end
   end

   assign A_o        = r_ab[0];
   assign B_o        = r_ab[1];
   assign busy_o     = r_busy;
   assign done_o     = r_done;
   assign pass_o     = r_pass;
   assign fail_vec_o = r_fail;
   assign err_cnt_o  = r_err;

endmodule
